ppu_line_buffer: RTL and testbench

PPU_LINE_BUFFER -- requirements
Module: ppu_line_buffer

---
 rtl/ppu_line_buffer_pkg.sv | 26 ++
 rtl/ppu_line_buffer_palette.sv | 20 ++
 rtl/ppu_line_buffer.sv | 113 +++++++++++
 tb/tb_ppu_line_buffer.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/ppu_line_buffer_pkg.sv
// Shared types and constants for the PPU-to-VGA scanline double buffer.
// Holds the bank-state encoding, the default geometry and the NES master palette.
package ppu_line_buffer_pkg;

  localparam int LINE_W_DEF = 256;
  localparam int IDX_W_DEF  = 6;

  typedef enum logic [1:0] {
    BANK_EMPTY = 2'd0,
    BANK_FILL  = 2'd1,
    BANK_FULL  = 2'd2
  } bank_state_e;

  // 12-bit RGB (4:4:4) approximation of the 2C02 master palette.
  localparam logic [11:0] NES_PALETTE [0:63] = '{
    12'h666, 12'h028, 12'h10A, 12'h309, 12'h508, 12'h605, 12'h600, 12'h410,
    12'h230, 12'h040, 12'h040, 12'h032, 12'h034, 12'h000, 12'h000, 12'h000,
    12'hAAA, 12'h05D, 12'h33F, 12'h81E, 12'hB0B, 12'hD06, 12'hC10, 12'hA30,
    12'h660, 12'h180, 12'h170, 12'h064, 12'h067, 12'h000, 12'h000, 12'h000,
    12'hFFF, 12'h5AF, 12'h88F, 12'hD6F, 12'hF5F, 12'hF6B, 12'hF73, 12'hE92,
    12'hBB1, 12'h6D2, 12'h3D5, 12'h2E9, 12'h2CE, 12'h444, 12'h000, 12'h000,
    12'hFFF, 12'hBDF, 12'hCCF, 12'hECF, 12'hFCF, 12'hFBE, 12'hFCB, 12'hFDA,
    12'hEE9, 12'hBE9, 12'hAEA, 12'hAFD, 12'hAEF, 12'hBBB, 12'h000, 12'h000
  };

endpackage

// File: rtl/ppu_line_buffer_palette.sv
// Registered palette lookup: index in, 12-bit RGB out one cycle later.
// A low enable forces black so misses and blanking need no extra mux downstream.
module nes_palette_rom
  import ppu_line_buffer_pkg::*;
#(
  parameter int IDX_W = IDX_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic [IDX_W-1:0] i_idx,
  output logic [11:0]      o_rgb
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) o_rgb <= '0;
    else        o_rgb <= i_en ? NES_PALETTE[i_idx] : 12'h000;
  end

endmodule

// File: rtl/ppu_line_buffer.sv
// Two-bank scanline buffer between the NES PPU pixel stream and a VGA timing block.
// The PPU fills one bank while the other is shown; each bank is tagged with its scanline.
module ppu_line_buffer
  import ppu_line_buffer_pkg::*;
#(
  parameter int LINE_W = LINE_W_DEF,
  parameter int IDX_W  = IDX_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pix_valid,
  output logic             pix_ready,
  input  logic [7:0]       pix_x,
  input  logic [7:0]       pix_y,
  input  logic [IDX_W-1:0] pix_idx,
  input  logic [7:0]       h_c,
  input  logic [7:0]       v_c,
  input  logic             de,
  output logic [3:0]       vgaRed,
  output logic [3:0]       vgaGreen,
  output logic [3:0]       vgaBlue,
  output logic             underrun
);

  localparam int         AW     = $clog2(LINE_W);
  localparam logic [7:0] LAST_X = 8'(LINE_W - 1);

  logic [IDX_W-1:0] r_mem [2][LINE_W];
  bank_state_e      r_state [2];
  logic [7:0]       r_tag [2];
  logic             r_wbank, r_rbank;
  logic [IDX_W-1:0] r_rd_idx;
  logic             r_hit_s1;
  logic             r_underrun;

  bank_state_e      w_state_nxt [2];
  logic [7:0]       w_tag_nxt [2];
  logic             w_acc, w_first, w_last;
  logic             w_rd_full, w_hit, w_eol;
  logic [11:0]      w_rgb;

  assign pix_ready = (r_state[r_wbank] != BANK_FULL);
  assign w_acc     = pix_valid && pix_ready;
  assign w_first   = w_acc && (pix_x == 8'd0);
  assign w_last    = w_acc && (pix_x == LAST_X);
  assign w_rd_full = (r_state[r_rbank] == BANK_FULL);
  assign w_hit     = de && w_rd_full && (r_tag[r_rbank] == v_c);
  assign w_eol     = de && (h_c == LAST_X);

  // Writer only touches a non-FULL bank and release only touches a FULL one,
  // so both updates can never target the same bank in one cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_tag_nxt   = r_tag;
    for (int b = 0; b < 2; b++) begin
      if (w_acc && (r_wbank == 1'(b))) begin
        if (w_first) begin
          w_state_nxt[b] = BANK_FILL;
          w_tag_nxt[b]   = pix_y;
        end
        if (w_last) w_state_nxt[b] = BANK_FULL;
      end
      if (w_eol && w_rd_full && (r_rbank == 1'(b))) w_state_nxt[b] = BANK_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) begin
        r_state[b] <= BANK_EMPTY;
        r_tag[b]   <= '0;
      end
      r_wbank <= 1'b0;
      r_rbank <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_tag   <= w_tag_nxt;
      if (w_last) r_wbank <= ~r_wbank;
      if (w_eol)  r_rbank <= ~r_rbank;
    end
  end

  // Line RAM is left unreset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (w_acc) r_mem[r_wbank][pix_x[AW-1:0]] <= pix_idx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_idx   <= '0;
      r_hit_s1   <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_rd_idx <= r_mem[r_rbank][h_c[AW-1:0]];
      r_hit_s1 <= w_hit;
      if (de && !w_hit) r_underrun <= 1'b1;
    end
  end

  nes_palette_rom #(.IDX_W(IDX_W)) u_pal (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (r_hit_s1),
    .i_idx (r_rd_idx),
    .o_rgb (w_rgb)
  );

  assign vgaRed   = w_rgb[11:8];
  assign vgaGreen = w_rgb[7:4];
  assign vgaBlue  = w_rgb[3:0];
  assign underrun = r_underrun;

endmodule

// File: tb/tb_ppu_line_buffer.sv
// Directed bench for ppu_line_buffer: fill/read, backpressure, misses, reset and blanking.
module tb_ppu_line_buffer;
  import ppu_line_buffer_pkg::*;

  logic       clk, rst_n;
  logic       pix_valid, pix_ready;
  logic [7:0] pix_x, pix_y;
  logic [5:0] pix_idx;
  logic [7:0] h_c, v_c;
  logic       de;
  logic [3:0] vgaRed, vgaGreen, vgaBlue;
  logic       underrun;

  int n_chk  = 0;
  int n_fail = 0;

  localparam logic [11:0] PAL [0:63] = '{
    12'h666, 12'h028, 12'h10A, 12'h309, 12'h508, 12'h605, 12'h600, 12'h410,
    12'h230, 12'h040, 12'h040, 12'h032, 12'h034, 12'h000, 12'h000, 12'h000,
    12'hAAA, 12'h05D, 12'h33F, 12'h81E, 12'hB0B, 12'hD06, 12'hC10, 12'hA30,
    12'h660, 12'h180, 12'h170, 12'h064, 12'h067, 12'h000, 12'h000, 12'h000,
    12'hFFF, 12'h5AF, 12'h88F, 12'hD6F, 12'hF5F, 12'hF6B, 12'hF73, 12'hE92,
    12'hBB1, 12'h6D2, 12'h3D5, 12'h2E9, 12'h2CE, 12'h444, 12'h000, 12'h000,
    12'hFFF, 12'hBDF, 12'hCCF, 12'hECF, 12'hFCF, 12'hFBE, 12'hFCB, 12'hFDA,
    12'hEE9, 12'hBE9, 12'hAEA, 12'hAFD, 12'hAEF, 12'hBBB, 12'h000, 12'h000
  };

  ppu_line_buffer #(.LINE_W(256), .IDX_W(6)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .pix_idx   (pix_idx),
    .h_c       (h_c),
    .v_c       (v_c),
    .de        (de),
    .vgaRed    (vgaRed),
    .vgaGreen  (vgaGreen),
    .vgaBlue   (vgaBlue),
    .underrun  (underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [5:0] pat(input int sel, input int x);
    case (sel)
      0:       return 6'(x % 64);
      1:       return 6'((x * 7 + 3) % 64);
      default: return 6'((255 - x) % 64);
    endcase
  endfunction

  task automatic reset_dut();
    rst_n = 1'b0; pix_valid = 1'b0; de = 1'b0; h_c = '0; v_c = '0;
    pix_x = '0; pix_y = '0; pix_idx = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check("rst_ready", 32'(pix_ready), 32'd1);
  endtask

  task automatic push(input int x, input int y, input int idx);
    pix_valid = 1'b1; pix_x = 8'(x); pix_y = 8'(y); pix_idx = 6'(idx);
    for (int n = 0; n < 600 && !pix_ready; n++) begin
      @(posedge clk); #1;
    end
    if (!pix_ready) check("push_timeout", 32'(pix_ready), 32'd1);
    @(posedge clk); #1;
    pix_valid = 1'b0;
  endtask

  task automatic write_line(input int y, input int sel);
    for (int x = 0; x < 256; x++) push(x, y, int'(pat(sel, x)));
  endtask

  // Colour for request i appears after the second following edge.
  task automatic sweep(input int v, input bit dv, input bit hit, input int sel,
                       input bit chk_rdy, input string tag);
    v_c = 8'(v);
    for (int i = 0; i <= 256; i++) begin
      if (i < 256) begin de = dv; h_c = 8'(i); end
      else de = 1'b0;
      @(posedge clk); #1;
      if (i >= 1)
        check(tag, 32'({vgaRed, vgaGreen, vgaBlue}), 32'(hit ? PAL[pat(sel, i - 1)] : 12'h000));
      if (chk_rdy) check({tag, "_rdy"}, 32'(pix_ready), 32'(i >= 255));
    end
    de = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; pix_valid = 1'b0; de = 1'b0; h_c = '0; v_c = '0;
    pix_x = '0; pix_y = '0; pix_idx = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rdy_low",  32'(pix_ready), 32'd1);
    check("rst_rgb",      32'({vgaRed, vgaGreen, vgaBlue}), 32'd0);
    check("rst_underrun", 32'(underrun), 32'd0);
    check("rst_bankA",    32'(dut.r_state[0]), 32'(BANK_EMPTY));
    check("rst_bankB",    32'(dut.r_state[1]), 32'(BANK_EMPTY));
    @(posedge clk); #1 rst_n = 1'b1;
    check("rel_ready", 32'(pix_ready), 32'd1);

    // Read before anything written: every visible pixel is a miss.
    sweep(7, 1'b1, 1'b0, 0, 1'b0, "empty_col");
    check("empty_underrun", 32'(underrun), 32'd1);
    repeat (5) @(posedge clk);
    #1 check("empty_underrun_sticky", 32'(underrun), 32'd1);

    reset_dut();
    write_line(0, 0);
    check("l0_ready", 32'(pix_ready), 32'd1);
    sweep(0, 1'b1, 1'b1, 0, 1'b0, "l0_col");
    check("l0_bankA_empty", 32'(dut.r_state[0]), 32'(BANK_EMPTY));
    check("l0_underrun", 32'(underrun), 32'd0);

    // Both banks full: writer stalls until bank A is released.
    reset_dut();
    write_line(5, 1);
    write_line(6, 2);
    check("full_ready0", 32'(pix_ready), 32'd0);
    repeat (20) @(posedge clk);
    #1 check("full_ready_hold", 32'(pix_ready), 32'd0);
    sweep(5, 1'b1, 1'b1, 1, 1'b1, "l5_col");
    sweep(6, 1'b1, 1'b1, 2, 1'b0, "l6_col");
    check("l56_underrun", 32'(underrun), 32'd0);

    // Tag mismatch: bank holds line 3, display wants line 4.
    reset_dut();
    write_line(3, 0);
    sweep(4, 1'b1, 1'b0, 0, 1'b0, "tagmiss_col");
    check("tagmiss_underrun", 32'(underrun), 32'd1);
    check("tagmiss_released", 32'(dut.r_state[0]), 32'(BANK_EMPTY));

    // Reset in the middle of a line.
    reset_dut();
    for (int x = 0; x <= 100; x++) push(x, 2, int'(pat(1, x)));
    rst_n = 1'b0;
    #1;
    check("midrst_ready", 32'(pix_ready), 32'd1);
    check("midrst_rgb",   32'({vgaRed, vgaGreen, vgaBlue}), 32'd0);
    check("midrst_bankA", 32'(dut.r_state[0]), 32'(BANK_EMPTY));
    check("midrst_bankB", 32'(dut.r_state[1]), 32'(BANK_EMPTY));
    @(posedge clk); #1 rst_n = 1'b1;
    write_line(2, 0);
    sweep(2, 1'b1, 1'b1, 0, 1'b0, "refill_col");
    check("refill_underrun", 32'(underrun), 32'd0);

    // Blanked line leaves the full bank untouched.
    reset_dut();
    write_line(9, 2);
    sweep(9, 1'b0, 1'b0, 2, 1'b0, "blank_col");
    check("blank_bank_full", 32'(dut.r_state[0]), 32'(BANK_FULL));
    check("blank_underrun",  32'(underrun), 32'd0);
    sweep(9, 1'b1, 1'b1, 2, 1'b0, "blank_then_show");
    check("show_underrun", 32'(underrun), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
